// File: rtl/player_pkg.sv
// Shared definitions for the player movement blocks: direction bit
// positions within a 4-bit move request and the arbitration FSM states.
package player_pkg;
  localparam int MV_UP    = 0;
  localparam int MV_DOWN  = 1;
  localparam int MV_LEFT  = 2;
  localparam int MV_RIGHT = 3;

  typedef enum logic {IDLE = 1'b0, ASK = 1'b1} state_t;
endpackage

// File: rtl/move_rr_arbiter.sv
// Round-robin grant over N request lines. The search starts at rr_ptr.
// rr_ptr moves to the slot after the finished owner when adv pulses.
module move_rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [N-1:0]  req,
  input  logic          adv,
  input  logic [IW-1:0] done_id,
  output logic          any,
  output logic [IW-1:0] gnt_id
);
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] cand;

  // first requester at or after rr_ptr, wrapping modulo N
  always_comb begin
    any    = 1'b0;
    gnt_id = '0;
    cand   = '0;
    for (int i = 0; i < N; i++) begin
      cand = IW'((int'(rr_ptr) + i) % N);
      if (!any && req[cand]) begin
        any    = 1'b1;
        gnt_id = cand;
      end
    end
  end

  // pointer follows the channel whose request just finished
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)    rr_ptr <= '0;
    else if (adv) rr_ptr <= (done_id == IW'(N - 1)) ? '0 : done_id + 1'b1;
  end
endmodule

// File: rtl/multi_player_move.sv
// Multi-channel movement controller. Bounds each player's direction
// request to one legal step, arbitrates eligible players round-robin onto
// a single ask/accept port, and commits the map logic's answer.
// Optional feature: define MOVE_TIMEOUT_EN to drop unanswered requests
// after TIMEOUT cycles in ASK.
module multi_player_move
  import player_pkg::*;
#(
  parameter int N_PLAYERS = 2,
  parameter int COORD_W   = 4,
  parameter int GRID_W    = 13,
  parameter int GRID_H    = 12,
  parameter logic [N_PLAYERS-1:0][COORD_W-1:0] INIT_X = {4'd6, 4'd6},
  parameter logic [N_PLAYERS-1:0][COORD_W-1:0] INIT_Y = {4'd11, 4'd0},
  parameter int TIMEOUT   = 15,
  localparam int IW       = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic [N_PLAYERS-1:0][3:0]          move,
  output logic                               ask_move,
  output logic [IW-1:0]                      ask_id,
  output logic [COORD_W-1:0]                 ask_x,
  output logic [COORD_W-1:0]                 ask_y,
  input  logic                               accept_move,
  input  logic                               reject_move,
  input  logic [COORD_W-1:0]                 goto_x,
  input  logic [COORD_W-1:0]                 goto_y,
  output logic [N_PLAYERS-1:0][COORD_W-1:0]  pos_x,
  output logic [N_PLAYERS-1:0][COORD_W-1:0]  pos_y,
  output logic [N_PLAYERS-1:0]               move_done,
  output logic                               timeout
);
  state_t                             state;
  logic [N_PLAYERS-1:0]               elig;
  logic [N_PLAYERS-1:0][COORD_W-1:0]  tgt_x, tgt_y;
  logic                               any;
  logic [IW-1:0]                      gnt_id;
  logic                               expire;
  logic                               adv;

  // per-channel bounding and single-step target
  for (genvar i = 0; i < N_PLAYERS; i++) begin : g_bound
    logic [3:0]         b;
    logic [COORD_W-1:0] tx, ty;

    // drop off-grid directions, then step on the highest-priority survivor
    always_comb begin
      b = move[i];
      if (pos_y[i] == '0)                    b[MV_UP]    = 1'b0;
      if (pos_y[i] == COORD_W'(GRID_H - 1))  b[MV_DOWN]  = 1'b0;
      if (pos_x[i] == '0)                    b[MV_LEFT]  = 1'b0;
      if (pos_x[i] == COORD_W'(GRID_W - 1))  b[MV_RIGHT] = 1'b0;
      tx = pos_x[i];
      ty = pos_y[i];
      if      (b[MV_UP])    ty = pos_y[i] - 1'b1;
      else if (b[MV_DOWN])  ty = pos_y[i] + 1'b1;
      else if (b[MV_LEFT])  tx = pos_x[i] - 1'b1;
      else if (b[MV_RIGHT]) tx = pos_x[i] + 1'b1;
    end

    assign elig[i]  = |b;
    assign tgt_x[i] = tx;
    assign tgt_y[i] = ty;
  end

`ifdef MOVE_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  logic [TW-1:0] tcnt;
  logic [TW:0]   tnext;
  assign tnext  = {1'b0, tcnt} + 1'b1;
  // this ASK cycle is the one in which the count would reach TIMEOUT
  assign expire = (state == ASK) && (tnext == (TW + 1)'(TIMEOUT));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT;
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  // any way out of ASK hands the pointer to the next channel
  assign adv = (state == ASK) && (accept_move || reject_move || expire);

  move_rr_arbiter #(.N(N_PLAYERS), .IW(IW)) u_arb (
    .clk     (clk),
    .rstn    (rstn),
    .req     (elig),
    .adv     (adv),
    .done_id (ask_id),
    .any     (any),
    .gnt_id  (gnt_id)
  );

  // request/answer FSM; owns committed positions and all registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      ask_move  <= 1'b0;
      ask_id    <= '0;
      ask_x     <= '0;
      ask_y     <= '0;
      pos_x     <= INIT_X;
      pos_y     <= INIT_Y;
      move_done <= '0;
`ifdef MOVE_TIMEOUT_EN
      tcnt      <= '0;
      timeout   <= 1'b0;
`endif
    end else begin
      move_done <= '0;
`ifdef MOVE_TIMEOUT_EN
      timeout   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (any) begin
            ask_id   <= gnt_id;
            ask_x    <= tgt_x[gnt_id];
            ask_y    <= tgt_y[gnt_id];
            ask_move <= 1'b1;
            state    <= ASK;
`ifdef MOVE_TIMEOUT_EN
            tcnt     <= '0;
`endif
          end
        end
        ASK: begin
          // accept outranks reject, and both outrank expiry
          if (accept_move) begin
            pos_x[ask_id]     <= goto_x;
            pos_y[ask_id]     <= goto_y;
            move_done[ask_id] <= 1'b1;
            ask_move          <= 1'b0;
            state             <= IDLE;
          end else if (reject_move) begin
            ask_move <= 1'b0;
            state    <= IDLE;
          end
`ifdef MOVE_TIMEOUT_EN
          else if (expire) begin
            timeout  <= 1'b1;
            ask_move <= 1'b0;
            state    <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multi_player_move.sv
// Scoreboard bench for multi_player_move: stimulus pushes expected asks and
// commits into queues; a monitor pops and compares when the DUT presents them.
module tb_multi_player_move;
  logic             clk = 1'b0;
  logic             rstn;
  logic [1:0][3:0]  move;
  logic             ask_move;
  logic [0:0]       ask_id;
  logic [3:0]       ask_x, ask_y;
  logic             accept_move, reject_move;
  logic [3:0]       goto_x, goto_y;
  logic [1:0][3:0]  pos_x, pos_y;
  logic [1:0]       move_done;
  logic             timeout;

  typedef struct {
    logic [0:0] id;
    logic [3:0] x;
    logic [3:0] y;
  } ev_t;

  ev_t ask_q[$];
  ev_t done_q[$];
  int  to_exp = 0;
  int  tests  = 0;
  int  fails  = 0;

  always #5 clk = ~clk;

  multi_player_move #(
    .N_PLAYERS(2), .COORD_W(4), .GRID_W(13), .GRID_H(12),
    .INIT_X({4'd6, 4'd6}), .INIT_Y({4'd11, 4'd0}), .TIMEOUT(3)
  ) dut (
    .clk(clk), .rstn(rstn), .move(move),
    .ask_move(ask_move), .ask_id(ask_id), .ask_x(ask_x), .ask_y(ask_y),
    .accept_move(accept_move), .reject_move(reject_move),
    .goto_x(goto_x), .goto_y(goto_y),
    .pos_x(pos_x), .pos_y(pos_y), .move_done(move_done), .timeout(timeout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_ask(input logic [0:0] id, input logic [3:0] x, input logic [3:0] y);
    ev_t e;
    e.id = id; e.x = x; e.y = y;
    ask_q.push_back(e);
  endtask

  task automatic push_done(input logic [0:0] id, input logic [3:0] x, input logic [3:0] y);
    ev_t e;
    e.id = id; e.x = x; e.y = y;
    done_q.push_back(e);
  endtask

  task automatic wait_ask();
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (ask_move) seen = 1'b1;
    end
    if (!seen) check("ask_wait_bound", 32'(ask_move), 32'd1);
  endtask

  task automatic answer(input logic a, input logic r, input logic [3:0] gx, input logic [3:0] gy);
    @(negedge clk);
    accept_move = a; reject_move = r; goto_x = gx; goto_y = gy;
    @(negedge clk);
    accept_move = 1'b0; reject_move = 1'b0;
  endtask

  task automatic check_reset();
    check("rst_ask_move", 32'(ask_move), 32'd0);
    check("rst_ask_id",   32'(ask_id),   32'd0);
    check("rst_ask_x",    32'(ask_x),    32'd0);
    check("rst_ask_y",    32'(ask_y),    32'd0);
    check("rst_pos_x0",   32'(pos_x[0]), 32'd6);
    check("rst_pos_y0",   32'(pos_y[0]), 32'd0);
    check("rst_pos_x1",   32'(pos_x[1]), 32'd6);
    check("rst_pos_y1",   32'(pos_y[1]), 32'd11);
    check("rst_done",     32'(move_done), 32'd0);
    check("rst_timeout",  32'(timeout),  32'd0);
  endtask

  // monitor: pops the expected entry whenever the DUT presents an event
  initial begin
    logic ask_prev;
    ev_t  e;
    ask_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (ask_move && !ask_prev) begin
        if (ask_q.size() == 0) check("unexpected_ask", 32'(ask_move), 32'd0);
        else begin
          e = ask_q.pop_front();
          check("ask_id", 32'(ask_id), 32'(e.id));
          check("ask_x",  32'(ask_x),  32'(e.x));
          check("ask_y",  32'(ask_y),  32'(e.y));
        end
      end
      ask_prev = ask_move;
      if (move_done != 2'b00) begin
        if (done_q.size() == 0) check("unexpected_done", 32'(move_done), 32'd0);
        else begin
          e = done_q.pop_front();
          check("done_mask", 32'(move_done), 32'(2'b01 << e.id));
          check("done_pos_x", 32'(pos_x[e.id]), 32'(e.x));
          check("done_pos_y", 32'(pos_y[e.id]), 32'(e.y));
          check("done_ask_low", 32'(ask_move), 32'd0);
        end
      end
      if (timeout) begin
        if (to_exp == 0) check("unexpected_timeout", 32'(timeout), 32'd0);
        else to_exp--;
      end
    end
  end

  logic [0:0] alt_id [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [3:0] alt_y  [4] = '{4'd2, 4'd10, 4'd3, 4'd9};

  initial begin
    bit stayed;
    rstn = 1'b0; move = '0; accept_move = 1'b0; reject_move = 1'b0;
    goto_x = '0; goto_y = '0;
    repeat (2) @(negedge clk);
    check_reset();
    rstn = 1'b1;
    @(negedge clk);

    // ch0 at (6,0) steps down
    push_ask(1'b0, 4'd6, 4'd1);
    move[0] = 4'b0010;
    wait_ask();
    move = '0;
    push_done(1'b0, 4'd6, 4'd1);
    answer(1'b1, 1'b0, 4'd6, 4'd1);

    // ch1 at bottom row: down is clipped, up survives; then reject
    push_ask(1'b1, 4'd6, 4'd10);
    move[1] = 4'b0011;
    wait_ask();
    move = '0;
    answer(1'b0, 1'b1, 4'd6, 4'd6);
    check("rej_pos_x1", 32'(pos_x[1]), 32'd6);
    check("rej_pos_y1", 32'(pos_y[1]), 32'd11);
    move[1] = 4'b0010;
    repeat (5) @(negedge clk);
    check("no_ask_bottom", 32'(ask_move), 32'd0);
    move = '0;

    // both channels request continuously: grants alternate
    for (int k = 0; k < 4; k++) begin
      push_ask(alt_id[k], 4'd6, alt_y[k]);
      push_done(alt_id[k], 4'd6, alt_y[k]);
    end
    move[0] = 4'b0010;
    move[1] = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      wait_ask();
      answer(1'b1, 1'b0, 4'd6, alt_y[k]);
    end
    move = '0;

    // accept and reject together commit; goto differs from the ask
    push_ask(1'b0, 4'd7, 4'd3);
    push_done(1'b0, 4'd9, 4'd4);
    move[0] = 4'b1000;
    wait_ask();
    move = '0;
    answer(1'b1, 1'b1, 4'd9, 4'd4);

    // goto committed unchecked onto the grid corner
    push_ask(1'b1, 4'd5, 4'd9);
    push_done(1'b1, 4'd12, 4'd0);
    move[1] = 4'b0100;
    wait_ask();
    move = '0;
    answer(1'b1, 1'b0, 4'd12, 4'd0);

    // at (12,0): up and right clipped, down remains
    push_ask(1'b1, 4'd12, 4'd1);
    move[1] = 4'b1011;
    wait_ask();
    move = '0;
    answer(1'b0, 1'b1, 4'd0, 4'd0);
    check("corner_pos_x1", 32'(pos_x[1]), 32'd12);
    move[1] = 4'b1001;
    repeat (5) @(negedge clk);
    check("no_ask_corner", 32'(ask_move), 32'd0);
    move = '0;

    // unanswered request
    push_ask(1'b0, 4'd9, 4'd3);
    move[0] = 4'b0001;
    wait_ask();
    move = '0;
`ifdef MOVE_TIMEOUT_EN
    to_exp = 1;
    @(negedge clk); check("to_early1", 32'(timeout), 32'd0);
    @(negedge clk); check("to_early2", 32'(timeout), 32'd0);
    @(negedge clk); check("to_pulse", 32'(timeout), 32'd1);
    check("to_ask_low", 32'(ask_move), 32'd0);
    check("to_pos_y0", 32'(pos_y[0]), 32'd4);
    push_ask(1'b0, 4'd9, 4'd3);
    move[0] = 4'b0001;
    wait_ask();
    move = '0;
`else
    stayed = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (!ask_move) stayed = 1'b0;
    end
    check("ask_held_100", 32'(stayed), 32'd1);
`endif

    // reset in the middle of ASK
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check_reset();
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_ask", 32'(ask_move), 32'd0);

    check("ask_q_drained",  32'(ask_q.size()),  32'd0);
    check("done_q_drained", 32'(done_q.size()), 32'd0);
    check("to_drained",     32'(to_exp),        32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
